// File: rtl/shared_buffer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shared_buf_pkg
// Brief    : Shared shift-buffer widths, chunk-size encodings and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package shared_buf_pkg;

    localparam int BUF_W  = 320;
    localparam int WORD_W = 64;
    localparam int OCC_W  = 9;

    localparam logic [1:0] CHUNK_40 = 2'd0;  // 4 x 10 bit
    localparam logic [1:0] CHUNK_52 = 2'd1;  // 4 x 13 bit
    localparam logic [1:0] CHUNK_48 = 2'd2;  // 4 x 12 bit
    localparam logic [1:0] CHUNK_16 = 2'd3;  // 4 x 4 bit

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    function automatic logic [OCC_W-1:0] chunk_width(input logic [1:0] sel);
        case (sel)
            CHUNK_40: return 9'd40;
            CHUNK_52: return 9'd52;
            CHUNK_48: return 9'd48;
            default:  return 9'd16;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/shared_buffer_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : shared_buffer_arbiter_if
// Brief    : Engine-side bundle of the shared buffer arbiter. The occ field
//            exists only when SHARED_BUF_OCC_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface shared_buffer_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import shared_buf_pkg::*;

    logic [NUM_REQ-1:0]        req;
    // One-cycle done pulse; named release_req because release is a keyword.
    logic [NUM_REQ-1:0]        release_req;
    logic [2*NUM_REQ-1:0]      chunk_sel;
    logic [NUM_REQ-1:0]        shift_small_en;
    logic [NUM_REQ-1:0]        shift64_en;
    logic [WORD_W*NUM_REQ-1:0] load_data;
    logic [NUM_REQ-1:0]        grant;
    logic [BUF_W-1:0]          buffer;
    logic                      busy;
    logic [2:0]                owner;
    logic                      protocol_err;
`ifdef SHARED_BUF_OCC_CHECK_EN
    logic [OCC_W-1:0]          occ;

    modport master (
        output req, release_req, chunk_sel, shift_small_en, shift64_en, load_data,
        input  grant, buffer, busy, owner, protocol_err, occ
    );
    modport slave (
        input  req, release_req, chunk_sel, shift_small_en, shift64_en, load_data,
        output grant, buffer, busy, owner, protocol_err, occ
    );
`else
    modport master (
        output req, release_req, chunk_sel, shift_small_en, shift64_en, load_data,
        input  grant, buffer, busy, owner, protocol_err
    );
    modport slave (
        input  req, release_req, chunk_sel, shift_small_en, shift64_en, load_data,
        output grant, buffer, busy, owner, protocol_err
    );
`endif

endinterface
`default_nettype wire

// File: rtl/shared_buffer_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  wire  [NUM_REQ-1:0] req,
    input  wire  [2:0]         ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         idx,
    output logic               any
);

    logic [NUM_REQ-1:0] w_rot;

    // Rotate so bit k is requester (ptr + k) mod NUM_REQ; ptr < NUM_REQ always.
    assign w_rot = NUM_REQ'({req, req} >> ptr);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                any = 1'b1;
                idx = 3'((int'(ptr) + k) % NUM_REQ);
            end
        end
        grant = any ? (NUM_REQ'(1) << idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/shared_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shared_buffer_arbiter
// Brief    : Round-robin owner of the shared 320-bit shift buffer; optional
//            occupancy checking under SHARED_BUF_OCC_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module shared_buffer_arbiter
    import shared_buf_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input wire                     clk,
    input wire                     rst,
    shared_buffer_arbiter_if.slave bus
);

    state_t             r_state;
    logic [2:0]         r_ptr;
    logic [2:0]         r_owner;
    logic [NUM_REQ-1:0] r_grant;
    logic [BUF_W-1:0]   r_buffer;
    logic               r_busy;
    logic               r_err;

    logic [NUM_REQ-1:0] w_pick;
    logic [2:0]         w_pick_idx;
    logic               w_pick_any;
    logic [2:0]         w_ptr_next;

    logic [NUM_REQ-1:0] w_own_mask;
    logic [NUM_REQ-1:0] w_act_mask;
    logic               w_own_valid;
    logic               w_own_small;
    logic               w_own_load;
    logic               w_own_rel;
    logic               w_own_req;
    logic [1:0]         w_own_sel;
    logic [WORD_W-1:0]  w_own_data;
    logic [OCC_W-1:0]   w_chunk;
    logic [BUF_W-1:0]   w_shifted;
    logic [BUF_W-1:0]   w_loaded;
    logic               w_foreign;
    logic               w_both;
    logic               w_leave;
    logic               w_occ_err;
    logic               w_err_now;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req   (bus.req),
        .ptr   (r_ptr),
        .grant (w_pick),
        .idx   (w_pick_idx),
        .any   (w_pick_any)
    );

    assign w_ptr_next = (w_pick_idx == 3'(NUM_REQ - 1)) ? 3'd0 : w_pick_idx + 3'd1;

    always_comb begin
        w_own_mask  = '0;
        w_own_small = 1'b0;
        w_own_load  = 1'b0;
        w_own_rel   = 1'b0;
        w_own_req   = 1'b0;
        w_own_sel   = '0;
        w_own_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == 3'(i)) begin
                w_own_mask[i] = 1'b1;
                w_own_small   = bus.shift_small_en[i];
                w_own_load    = bus.shift64_en[i];
                w_own_rel     = bus.release_req[i];
                w_own_req     = bus.req[i];
                w_own_sel     = bus.chunk_sel[2*i +: 2];
                w_own_data    = bus.load_data[WORD_W*i +: WORD_W];
            end
        end
    end

    assign w_own_valid = |w_own_mask;
    assign w_act_mask  = (r_state == ST_OWNED) ? w_own_mask : '0;
    assign w_chunk     = chunk_width(w_own_sel);
    assign w_shifted   = r_buffer >> w_chunk;
    assign w_loaded    = {w_own_data, r_buffer[BUF_W-1:WORD_W]};
    assign w_leave     = w_own_rel | ~w_own_req;

    // Outside OWNED nobody holds the buffer, so every strobe or release is foreign.
    assign w_foreign = |((bus.shift_small_en | bus.shift64_en | bus.release_req) & ~w_act_mask);
    assign w_both    = (r_state == ST_OWNED) & w_own_small & w_own_load;

`ifdef SHARED_BUF_OCC_CHECK_EN
    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] w_occ_next;

    always_comb begin
        w_occ_err  = 1'b0;
        w_occ_next = r_occ;
        if (r_state == ST_OWNED && w_own_valid) begin
            if (w_own_small) begin
                w_occ_err  = (r_occ < w_chunk);
                w_occ_next = w_occ_err ? '0 : r_occ - w_chunk;
            end else if (w_own_load) begin
                w_occ_err  = (r_occ > 9'(BUF_W - WORD_W));
                w_occ_next = w_occ_err ? 9'(BUF_W) : r_occ + 9'(WORD_W);
            end
        end
    end

    assign bus.occ = r_occ;
`else
    assign w_occ_err = 1'b0;
`endif

    assign w_err_now = w_foreign | w_both | w_occ_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_grant  <= '0;
            r_buffer <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
`ifdef SHARED_BUF_OCC_CHECK_EN
            r_occ    <= '0;
`endif
        end else begin
            if (w_err_now) begin
                r_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_grant <= w_pick;
                        r_owner <= w_pick_idx;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_ptr_next;
                        r_state <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (!w_own_valid) begin
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        // Small shift wins over a simultaneous load.
                        if (w_own_small) begin
                            r_buffer <= w_shifted;
                        end else if (w_own_load) begin
                            r_buffer <= w_loaded;
                        end
`ifdef SHARED_BUF_OCC_CHECK_EN
                        r_occ <= w_occ_next;
`endif
                        if (w_leave) begin
                            r_grant <= '0;
                            r_busy  <= 1'b0;
                            r_state <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_buffer <= '0;
`ifdef SHARED_BUF_OCC_CHECK_EN
                    r_occ    <= '0;
`endif
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.grant        = r_grant;
    assign bus.buffer       = r_buffer;
    assign bus.busy         = r_busy;
    assign bus.owner        = r_owner;
    assign bus.protocol_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_shared_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_buffer_arbiter
// Brief    : Directed plus random stimulus against a behavioural model of the
//            shared buffer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_buffer_arbiter;
    import shared_buf_pkg::*;

    localparam int N = 4;
    localparam logic [63:0] PAT = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] WA  = 64'hA5A5_5A5A_0F0F_F0F0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    shared_buffer_arbiter_if #(.NUM_REQ(N)) bus ();

    shared_buffer_arbiter #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Model: who owns the buffer, whether a clear cycle is pending, the rotation
    // pointer, buffer contents, sticky error and valid-bit count.
    int               m_owner;
    int               m_ptr;
    int               m_occ;
    bit               m_clear;
    bit               m_err;
    logic [BUF_W-1:0] m_buf;

    function automatic int width_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return 40;
            2'd1:    return 52;
            2'd2:    return 48;
            default: return 16;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [BUF_W-1:0] got, input logic [BUF_W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_occ   = 0;
        m_clear = 1'b0;
        m_err   = 1'b0;
        m_buf   = '0;
    endtask

    task automatic model_edge();
        bit e;
        bit found;
        e = 1'b0;
        found = 1'b0;
        if (m_owner < 0) begin
            if ((bus.shift_small_en | bus.shift64_en | bus.release_req) != '0) e = 1'b1;
            if (m_clear) begin
                m_buf   = '0;
                m_occ   = 0;
                m_clear = 1'b0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (!found && bus.req[c]) begin
                        found   = 1'b1;
                        m_owner = c;
                        m_ptr   = (c + 1) % N;
                    end
                end
            end
        end else begin
            int o;
            int n;
            o = m_owner;
            for (int i = 0; i < N; i++)
                if (i != o && (bus.shift_small_en[i] || bus.shift64_en[i] || bus.release_req[i])) e = 1'b1;
            if (bus.shift_small_en[o] && bus.shift64_en[o]) e = 1'b1;
            if (bus.shift_small_en[o]) begin
                n = width_of(bus.chunk_sel[2*o +: 2]);
`ifdef SHARED_BUF_OCC_CHECK_EN
                if (m_occ < n) e = 1'b1;
`endif
                m_buf = m_buf >> n;
                m_occ = (m_occ > n) ? m_occ - n : 0;
            end else if (bus.shift64_en[o]) begin
`ifdef SHARED_BUF_OCC_CHECK_EN
                if (m_occ > BUF_W - 64) e = 1'b1;
`endif
                m_buf = {bus.load_data[64*o +: 64], m_buf[BUF_W-1:64]};
                m_occ = (m_occ + 64 > BUF_W) ? BUF_W : m_occ + 64;
            end
            if (bus.release_req[o] || !bus.req[o]) begin
                m_owner = -1;
                m_clear = 1'b1;
            end
        end
        if (e) m_err = 1'b1;
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        chk("grant", BUF_W'(bus.grant), BUF_W'(eg));
        chk("busy", BUF_W'(bus.busy), BUF_W'(m_owner >= 0));
        chk("buffer", bus.buffer, m_buf);
        chk("protocol_err", BUF_W'(bus.protocol_err), BUF_W'(m_err));
        if (m_owner >= 0) chk("owner", BUF_W'(bus.owner), BUF_W'(m_owner));
`ifdef SHARED_BUF_OCC_CHECK_EN
        chk("occ", BUF_W'(bus.occ), BUF_W'(m_occ));
`endif
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clear_strobes();
        bus.shift_small_en = '0;
        bus.shift64_en     = '0;
        bus.release_req    = '0;
    endtask

    // Asserts rst between edges, checks the asynchronous clear, releases mid-cycle.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_grant", BUF_W'(bus.grant), '0);
        chk("rst_buffer", bus.buffer, '0);
        chk("rst_busy", BUF_W'(bus.busy), '0);
        chk("rst_err", BUF_W'(bus.protocol_err), '0);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BUF_W-1:0] orig;
        logic [63:0]      w;
        int               cnt;

        bus.req       = '0;
        bus.chunk_sel = '0;
        bus.load_data = '0;
        clear_strobes();
        model_reset();
        do_reset();

        // Single owner: five loads then eight 40-bit shifts.
        bus.req = 4'b0001;
        step();
        chk("t1_grant", BUF_W'(bus.grant), BUF_W'(4'b0001));
        orig = '0;
        for (int j = 0; j < 5; j++) begin
            w = PAT + 64'(j) * 64'h1111_1111_1111_1111;
            orig[64*j +: 64] = w;
            bus.load_data[63:0] = w;
            bus.shift64_en[0]   = 1'b1;
            step();
        end
        clear_strobes();
        bus.chunk_sel[1:0] = 2'd0;
        for (int k = 0; k < 8; k++) begin
            chk("t1_slice", BUF_W'(bus.buffer[39:0]), BUF_W'(orig[40*k +: 40]));
            bus.shift_small_en[0] = 1'b1;
            step();
        end
        clear_strobes();
        bus.release_req[0] = 1'b1;
        bus.req = '0;
        step();
        clear_strobes();
        step();
        chk("t1_clear_buf", bus.buffer, '0);
        chk("t1_clear_busy", BUF_W'(bus.busy), '0);

        // Round robin with all requesters held.
        do_reset();
        bus.req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            cnt = 0;
            while (bus.grant == '0 && cnt < 10) begin
                step();
                cnt++;
            end
            chk("t2_order", BUF_W'(bus.owner), BUF_W'(r % N));
            // Pulse-sampling edge plus these two edges makes three.
            if (r > 0) chk("t2_gap", BUF_W'(cnt), BUF_W'(2));
            step();
            step();
            bus.release_req[r % N] = 1'b1;
            step();
            clear_strobes();
        end

        // Chunk widths for owner 2.
        for (int s = 0; s < 2; s++) begin
            do_reset();
            bus.req = 4'b0100;
            step();
            bus.load_data = {N{64'hFFFF_FFFF_FFFF_FFFF}};
            for (int j = 0; j < 5; j++) begin
                bus.shift64_en[2] = 1'b1;
                step();
            end
            clear_strobes();
            bus.chunk_sel[5:4] = (s == 0) ? 2'd1 : 2'd3;
            bus.shift_small_en[2] = 1'b1;
            step();
            clear_strobes();
            if (s == 0) chk("t3_chunk52", bus.buffer, {52'b0, {268{1'b1}}});
            else        chk("t3_chunk16", bus.buffer, {16'b0, {304{1'b1}}});
        end

        // Protocol errors.
        do_reset();
        bus.req = 4'b0001;
        step();
        bus.load_data = {N{WA}};
        bus.shift64_en[0] = 1'b1;
        step();
        clear_strobes();
        bus.shift64_en[1] = 1'b1;
        step();
        clear_strobes();
        chk("t4_foreign_buf", bus.buffer, {WA, 256'b0});
        chk("t4_foreign_err", BUF_W'(bus.protocol_err), BUF_W'(1));
        bus.chunk_sel[1:0]    = 2'd0;
        bus.shift_small_en[0] = 1'b1;
        bus.shift64_en[0]     = 1'b1;
        step();
        clear_strobes();
        chk("t4_both_buf", bus.buffer, {40'b0, WA, 216'b0});
        step();
        step();
        step();
        chk("t4_sticky", BUF_W'(bus.protocol_err), BUF_W'(1));

        // Reset while owner 1 is loading.
        do_reset();
        bus.req = 4'b0010;
        step();
        bus.shift64_en[1] = 1'b1;
        step();
        do_reset();
        clear_strobes();
        step();
        chk("t5_regrant", BUF_W'(bus.grant), BUF_W'(4'b0010));

`ifdef SHARED_BUF_OCC_CHECK_EN
        // Occupancy overflow and underflow.
        do_reset();
        bus.req = 4'b0001;
        step();
        for (int j = 0; j < 6; j++) begin
            bus.shift64_en[0] = 1'b1;
            step();
            if (j == 4) begin
                chk("t6_occ_full", BUF_W'(bus.occ), BUF_W'(320));
                chk("t6_no_err", BUF_W'(bus.protocol_err), '0);
            end
            if (j == 5) chk("t6_over_err", BUF_W'(bus.protocol_err), BUF_W'(1));
        end
        clear_strobes();
        do_reset();
        bus.req = 4'b0001;
        step();
        bus.shift_small_en[0] = 1'b1;
        step();
        clear_strobes();
        chk("t6_under_err", BUF_W'(bus.protocol_err), BUF_W'(1));
        chk("t6_under_occ", BUF_W'(bus.occ), '0);
`endif

        // Random traffic, mostly well-behaved, with occasional foreign strobes.
        bus.req = '0;
        clear_strobes();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (c == 200) begin
                bus.req = '0;
                clear_strobes();
                do_reset();
            end
            clear_strobes();
            for (int i = 0; i < N; i++) begin
                if (i == m_owner)  bus.req[i] = ($urandom_range(0, 15) != 0);
                else if (!bus.req[i]) bus.req[i] = ($urandom_range(0, 3) == 0);
            end
            bus.chunk_sel = 8'($urandom);
            for (int wd = 0; wd < N; wd++) bus.load_data[64*wd +: 64] = {$urandom, $urandom};
            if (m_owner >= 0) begin
                bus.shift_small_en[m_owner] = ($urandom_range(0, 2) == 0);
                if (!bus.shift_small_en[m_owner])
                    bus.shift64_en[m_owner] = ($urandom_range(0, 1) == 0);
                bus.release_req[m_owner] = ($urandom_range(0, 9) == 0);
            end
            if ($urandom_range(0, 59) == 0) bus.shift64_en[$urandom_range(0, N - 1)] = 1'b1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
